i2s_dac_tx: RTL and testbench

- Serial transmit stage between the tone/sample source (16-bit LDATA/RDATA, data_over sample request) and the WM8731 DAC pins.
- The codec is bus master: AUD_BCLK and AUD_DACLRCK are inputs.
- The block synchronizes both inputs into the Clk domain and latches one stereo sample per frame.
- It shifts each channel out MSB-first on AUD_DACDAT and pulses data_over once per frame to request the next sample.

---
 rtl/audio_pkg.sv | 17 +
 rtl/i2s_dac_tx_if.sv | 23 ++
 rtl/sync_edge_det.sv | 30 +++
 rtl/i2s_dac_tx.sv | 142 ++++++++++++++
 tb/tb_i2s_dac_tx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio transmit path.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t DELAY = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t PAD   = 2'd3;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_e;

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample-source side of the DAC transmitter: stereo sample in, request/status out.
interface i2s_dac_tx_if
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W
);
  logic             enable;
  logic [WIDTH-1:0] LDATA;
  logic [WIDTH-1:0] RDATA;
  logic             data_over;
  logic             frame_err;
  logic             busy;

  modport master (
    output enable, LDATA, RDATA,
    input  data_over, frame_err, busy
  );

  modport slave (
    input  enable, LDATA, RDATA,
    output data_over, frame_err, busy
  );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, with a history flop for edge pulses.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// Serial transmitter to a codec-mastered DAC port: latches one stereo sample per LRCK
// frame and shifts each channel out MSB-first on BCLK falling edges.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH       = SAMPLE_W,
  parameter bit          I2S_MODE    = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  i2s_dac_tx_if.slave  src,
  input  logic         AUD_BCLK,
  input  logic         AUD_DACLRCK,
  output logic         AUD_DACDAT
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

  logic bclk_level, bclk_rise, bclk_fall;
  logic lrck_level, lrck_rise, lrck_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (AUD_BCLK),
    .level    (bclk_level),
    .rise     (bclk_rise),
    .fall     (bclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (AUD_DACLRCK),
    .level    (lrck_level),
    .rise     (lrck_rise),
    .fall     (lrck_fall)
  );

  state_t           state_q, state_d;
  channel_e         chan_q, chan_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dat_q, dat_d;
  logic             over_q, over_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] start_word;

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    dat_d      = dat_q;
    over_d     = 1'b0;
    err_d      = 1'b0;
    start_word = shift_q;

    if (!src.enable) begin
      state_d = IDLE;
      dat_d   = 1'b0;
    end else if (lrck_fall || (lrck_rise && state_q != IDLE)) begin
      // An LRCK edge always wins over a coincident BCLK fall; a channel cut short is abandoned.
      err_d = (state_q == DELAY) || (state_q == SHIFT && cnt_q != LAST_BIT);
      if (lrck_fall) begin
        hold_d     = src.RDATA;
        start_word = src.LDATA;
        over_d     = 1'b1;
        chan_d     = LEFT;
      end else begin
        start_word = hold_q;
        chan_d     = RIGHT;
      end
      shift_d = start_word;
      if (I2S_MODE) begin
        state_d = DELAY;
        dat_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = SHIFT;
        dat_d   = start_word[WIDTH-1];
        cnt_d   = CW'(1);
      end
    end else if (bclk_fall) begin
      case (state_q)
        DELAY: begin
          dat_d   = shift_q[WIDTH-1];
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            dat_d   = 1'b0;
            state_d = PAD;
          end else begin
            // shift_q has been advanced once per emitted bit after the MSB.
            dat_d   = shift_q[WIDTH-2];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      chan_q  <= LEFT;
      shift_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      dat_q   <= 1'b0;
      over_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      over_q  <= over_d;
      err_q   <= err_d;
    end
  end

  assign AUD_DACDAT    = dat_q;
  assign src.data_over = over_q;
  assign src.frame_err = err_q;
  assign src.busy      = (state_q != IDLE);

  // Current channel is tracked for debug visibility only.
  logic unused_dbg;
  assign unused_dbg = ^{bclk_level, bclk_rise, lrck_level, chan_q};

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Drives both I2S and left-justified variants from one codec-style BCLK/LRCK source
// and decodes their serial output against the sample values presented per frame.
module tb_i2s_dac_tx;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic AUD_BCLK = 1'b0;
  logic AUD_DACLRCK = 1'b0;
  logic dat_a, dat_b;
  logic enable;
  logic [15:0] ldata, rdata;

  int checks = 0;
  int failures = 0;

  i2s_dac_tx_if #(.WIDTH(16)) io_a ();
  i2s_dac_tx_if #(.WIDTH(16)) io_b ();

  assign io_a.enable = enable;
  assign io_a.LDATA  = ldata;
  assign io_a.RDATA  = rdata;
  assign io_b.enable = enable;
  assign io_b.LDATA  = ldata;
  assign io_b.RDATA  = rdata;

  i2s_dac_tx #(.WIDTH(16), .I2S_MODE(1'b1), .SYNC_STAGES(2)) dut_a (
    .Clk         (Clk),
    .Reset       (Reset),
    .src         (io_a),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (dat_a)
  );

  i2s_dac_tx #(.WIDTH(16), .I2S_MODE(1'b0), .SYNC_STAGES(2)) dut_b (
    .Clk         (Clk),
    .Reset       (Reset),
    .src         (io_b),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (dat_b)
  );

  always #10 Clk = ~Clk;

  // Per-channel observations: index 0 = I2S variant, 1 = left-justified variant.
  logic bits_a [64];
  logic bits_b [64];
  int   nbits;
  int   cyc;
  int   n_over [2];
  int   n_err [2];
  int   lat [2];
  int   busy_seen [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
    if (io_a.data_over) begin n_over[0]++; if (lat[0] == 0) lat[0] = cyc; end
    if (io_b.data_over) begin n_over[1]++; if (lat[1] == 0) lat[1] = cyc; end
    if (io_a.frame_err) n_err[0]++;
    if (io_b.frame_err) n_err[1]++;
    if (io_a.busy) busy_seen[0] = 1;
    if (io_b.busy) busy_seen[1] = 1;
  endtask

  // ev: 0 plain, 1 change LDATA one Clk after data_over, 2 drop enable at bit `at`,
  // 3 pulse Reset at bit `at`.
  task automatic run_channel(input logic lr, input int nb, input int ev, input int at,
                             input logic [15:0] new_l);
    cyc = 0;
    nbits = nb;
    for (int d = 0; d < 2; d++) begin
      n_over[d] = 0; n_err[d] = 0; lat[d] = 0; busy_seen[d] = 0;
    end
    for (int i = 0; i < nb; i++) begin
      if (ev == 2 && i == at) begin
        enable = 1'b0;
        tick();
        check("en_drop_dat_i2s", 32'(dat_a), 32'd0);
        check("en_drop_dat_lj", 32'(dat_b), 32'd0);
        check("en_drop_busy_i2s", 32'(io_a.busy), 32'd0);
        check("en_drop_busy_lj", 32'(io_b.busy), 32'd0);
      end
      if (ev == 3 && i == at) begin
        #3 Reset = 1'b0;
        #1;
        check("rst_dat_i2s", 32'(dat_a), 32'd0);
        check("rst_dat_lj", 32'(dat_b), 32'd0);
        check("rst_busy_i2s", 32'(io_a.busy), 32'd0);
        check("rst_busy_lj", 32'(io_b.busy), 32'd0);
        check("rst_over_i2s", 32'(io_a.data_over), 32'd0);
        check("rst_over_lj", 32'(io_b.data_over), 32'd0);
        tick();
        Reset = 1'b1;
      end
      AUD_BCLK = 1'b0;
      if (i == 0) AUD_DACLRCK = lr;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (ev == 1 && cyc == 4) ldata = new_l;
      end
      AUD_BCLK = 1'b1;
      bits_a[i] = dat_a;
      bits_b[i] = dat_b;
      repeat (8) tick();
    end
  endtask

  function automatic logic [31:0] word_of(input int which, input int off);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 16; j++)
      w = {w[30:0], (which == 0) ? bits_a[off + j] : bits_b[off + j]};
    return w;
  endfunction

  function automatic int stray_ones(input int which, input int off);
    int n;
    n = 0;
    for (int j = 0; j < nbits; j++)
      if ((j < off || j >= off + 16) && ((which == 0) ? bits_a[j] : bits_b[j]) === 1'b1) n++;
    return n;
  endfunction

  // Reference: I2S puts the word on BCLK rises 2..17, left-justified on rises 1..16.
  task automatic check_half(input string tag, input logic [15:0] exp);
    check({tag, "_word_i2s"}, word_of(0, 1), 32'(exp));
    check({tag, "_word_lj"}, word_of(1, 0), 32'(exp));
    check({tag, "_pad_i2s"}, 32'(stray_ones(0, 1)), 32'd0);
    check({tag, "_pad_lj"}, 32'(stray_ones(1, 0)), 32'd0);
  endtask

  task automatic check_counts(input string tag, input int over, input int err);
    for (int d = 0; d < 2; d++) begin
      check({tag, (d == 0) ? "_over_i2s" : "_over_lj"}, 32'(n_over[d]), 32'(over));
      check({tag, (d == 0) ? "_err_i2s" : "_err_lj"}, 32'(n_err[d]), 32'(err));
      if (over != 0) check({tag, (d == 0) ? "_lat_i2s" : "_lat_lj"}, 32'(lat[d]), 32'd3);
    end
  endtask

  task automatic check_silent(input string tag);
    check({tag, "_ones_i2s"}, 32'(stray_ones(0, 64)), 32'd0);
    check({tag, "_ones_lj"}, 32'(stray_ones(1, 64)), 32'd0);
    check({tag, "_busy_i2s"}, 32'(busy_seen[0]), 32'd0);
    check({tag, "_busy_lj"}, 32'(busy_seen[1]), 32'd0);
    check({tag, "_over_i2s"}, 32'(n_over[0]), 32'd0);
    check({tag, "_over_lj"}, 32'(n_over[1]), 32'd0);
  endtask

  task automatic full_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
    ldata = l;
    rdata = r;
    run_channel(1'b0, 32, 0, -1, 16'h0);
    check_half({tag, "_L"}, l);
    check_counts({tag, "_L"}, 1, 0);
    rdata = 16'($urandom);
    run_channel(1'b1, 32, 0, -1, 16'h0);
    check_half({tag, "_R"}, r);
    check_counts({tag, "_R"}, 0, 0);
  endtask

  logic [15:0] rl, rr;

  initial begin
    enable = 1'b1;
    ldata  = '0;
    rdata  = '0;
    repeat (3) @(negedge Clk);
    check("reset_dat_i2s", 32'(dat_a), 32'd0);
    check("reset_dat_lj", 32'(dat_b), 32'd0);
    check("reset_busy_i2s", 32'(io_a.busy), 32'd0);
    check("reset_busy_lj", 32'(io_b.busy), 32'd0);
    check("reset_over_i2s", 32'(io_a.data_over), 32'd0);
    check("reset_err_lj", 32'(io_b.frame_err), 32'd0);
    Reset = 1'b1;

    // A right half straight after reset must be ignored.
    run_channel(1'b1, 32, 0, -1, 16'h0);
    check_silent("idle_right");

    full_frame("f1", 16'hC000, 16'h0001);

    // LDATA changes one Clk after data_over: applies to the following frame only.
    ldata = 16'hC000;
    rr    = 16'($urandom);
    rdata = rr;
    run_channel(1'b0, 32, 1, -1, 16'h1234);
    check_half("late_L", 16'hC000);
    check_counts("late_L", 1, 0);
    run_channel(1'b1, 32, 0, -1, 16'h0);
    check_half("late_R", rr);
    full_frame("next", 16'h1234, 16'($urandom));

    for (int f = 0; f < 3; f++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      full_frame("rand", rl, rr);
    end

    // Short left channel: LRCK rises after only 10 BCLKs.
    ldata = 16'($urandom);
    rdata = 16'h0001;
    run_channel(1'b0, 10, 0, -1, 16'h0);
    check_counts("short_L", 1, 0);
    run_channel(1'b1, 32, 0, -1, 16'h0);
    check_half("short_R", 16'h0001);
    check_counts("short_R", 0, 1);

    full_frame("lj8001", 16'h8001, 16'($urandom));
    ldata = 16'h8001;
    run_channel(1'b0, 32, 0, -1, 16'h0);
    check("lj_first_rise_msb", 32'(bits_b[0]), 32'd1);
    check("lj_rise16_lsb", 32'(bits_b[15]), 32'd1);
    check("lj_rise17_zero", 32'(bits_b[16]), 32'd0);
    run_channel(1'b1, 32, 0, -1, 16'h0);

    // Enable dropped mid-left, disabled frame, re-enable during a right half.
    ldata = 16'hFFFF;
    run_channel(1'b0, 32, 2, 6, 16'h0);
    check_counts("drop_L", 1, 0);
    run_channel(1'b1, 32, 0, -1, 16'h0);
    check_silent("dis_R");
    run_channel(1'b0, 32, 0, -1, 16'h0);
    check_silent("dis_L");
    enable = 1'b1;
    run_channel(1'b1, 32, 0, -1, 16'h0);
    check_silent("reen_R");
    full_frame("reen", 16'($urandom), 16'($urandom));

    // Reset pulsed mid-left while shifting ones.
    ldata = 16'hFFFF;
    run_channel(1'b0, 32, 3, 8, 16'h0);
    run_channel(1'b1, 32, 0, -1, 16'h0);
    check_silent("post_rst_R");
    full_frame("post_rst", 16'($urandom), 16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
